// File: rtl/machine_timer.sv
// rtl/machine_timer.sv - memory-mapped 64-bit machine timer with prescaler and timer interrupt request

module machine_timer #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 2,
   parameter int DIV_WIDTH  = 8
) (
   input  logic                    clk,
   input  logic                    arstn,
   input  logic                    i_req_valid,
   output logic                    o_req_ready,
   input  logic                    i_req_write,
   input  logic [ADDR_WIDTH-1:0]   i_req_addr,
   input  logic [DATA_WIDTH-1:0]   i_req_wdata,
   input  logic [DATA_WIDTH/8-1:0] i_req_wstrb,
   output logic                    o_rsp_valid,
   input  logic                    i_rsp_ready,
   output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
   output logic                    o_rsp_err,
   output logic                    o_timer_int_call
);

   localparam int NB = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH-1:0] ADDR_MTIME = ADDR_WIDTH'(0);
   localparam logic [ADDR_WIDTH-1:0] ADDR_CMP   = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL  = ADDR_WIDTH'(2);

   logic [DATA_WIDTH-1:0] mtime;
   logic [DATA_WIDTH-1:0] mtimecmp;
   logic                  en;
   logic [DIV_WIDTH-1:0]  div;
   logic [DIV_WIDTH-1:0]  cnt;

   logic                  accept;
   logic                  tick;
   logic                  addr_ok;
   logic                  wr_mtime;
   logic                  wr_cmp;
   logic                  wr_ctrl;
   logic                  strb_any;
   logic [DATA_WIDTH-1:0] mtime_inc;
   logic [DATA_WIDTH-1:0] mtime_nxt;
   logic [DATA_WIDTH-1:0] cmp_nxt;
   logic [DATA_WIDTH-1:0] ctrl_val;
   logic [DATA_WIDTH-1:0] rd_val;
   logic                  en_wr;
   logic [DIV_WIDTH-1:0]  div_wr;

   // A new request can enter whenever the response slot is empty or draining this cycle.
   assign o_req_ready = ~o_rsp_valid | i_rsp_ready;
   assign accept      = i_req_valid & o_req_ready;
   assign addr_ok     = (i_req_addr == ADDR_MTIME) | (i_req_addr == ADDR_CMP) | (i_req_addr == ADDR_CTRL);
   assign wr_mtime    = accept & i_req_write & (i_req_addr == ADDR_MTIME);
   assign wr_cmp      = accept & i_req_write & (i_req_addr == ADDR_CMP);
   assign wr_ctrl     = accept & i_req_write & (i_req_addr == ADDR_CTRL);
   assign strb_any    = |i_req_wstrb;
   assign tick        = en & (cnt == div);
   assign mtime_inc   = mtime + DATA_WIDTH'(tick);

   // Byte-merge write data over the next-state values; unwritten MTIME bytes keep the incremented count.
   always_comb begin
      mtime_nxt = mtime_inc;
      cmp_nxt   = mtimecmp;
      for (int b = 0; b < NB; b++) begin
         if (i_req_wstrb[b]) begin
            if (wr_mtime) mtime_nxt[8*b +: 8] = i_req_wdata[8*b +: 8];
            if (wr_cmp)   cmp_nxt[8*b +: 8]   = i_req_wdata[8*b +: 8];
         end
      end
   end

   // Only the enable bit and the divisor field of CTRL are writable.
   always_comb begin
      en_wr  = en;
      div_wr = div;
      if (i_req_wstrb[0]) en_wr = i_req_wdata[0];
      for (int i = 0; i < DIV_WIDTH; i++) begin
         if (i_req_wstrb[(8 + i) / 8]) div_wr[i] = i_req_wdata[8 + i];
      end
   end

   // Read mux: registers as they stand in the acceptance cycle, CTRL zero-extended.
   always_comb begin
      ctrl_val                  = '0;
      ctrl_val[0]               = en;
      ctrl_val[8 +: DIV_WIDTH]  = div;
      rd_val                    = '0;
      if (i_req_addr == ADDR_MTIME)     rd_val = mtime;
      else if (i_req_addr == ADDR_CMP)  rd_val = mtimecmp;
      else if (i_req_addr == ADDR_CTRL) rd_val = ctrl_val;
   end

   // Timer registers and control fields.
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         mtime    <= '0;
         mtimecmp <= '1;
         en       <= 1'b1;
         div      <= '0;
      end else begin
         mtime    <= mtime_nxt;
         mtimecmp <= cmp_nxt;
         if (wr_ctrl) begin
            en  <= en_wr;
            div <= div_wr;
         end
      end
   end

   // Prescale counter: 0..div while enabled; restarts on every non-empty CTRL write.
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         cnt <= '0;
      end else if (wr_ctrl && strb_any) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + DIV_WIDTH'(1);
      end
   end

   // Response slot: loaded on accept, held until consumed.
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         o_rsp_valid <= 1'b0;
         o_rsp_rdata <= '0;
         o_rsp_err   <= 1'b0;
      end else if (accept) begin
         o_rsp_valid <= 1'b1;
         o_rsp_err   <= ~addr_ok;
         o_rsp_rdata <= (i_req_write || !addr_ok) ? '0 : rd_val;
      end else if (i_rsp_ready) begin
         o_rsp_valid <= 1'b0;
         o_rsp_rdata <= '0;
         o_rsp_err   <= 1'b0;
      end
   end

   // Level interrupt request from the current register values.
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         o_timer_int_call <= 1'b0;
      end else begin
         o_timer_int_call <= (mtime >= mtimecmp);
      end
   end

endmodule
